npu_seq_ctrl: RTL

NPU_SEQ_CTRL -- requirements
Module: npu_seq_ctrl

---
 rtl/npu_seq_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/npu_seq_ctrl.sv
// npu_seq_ctrl -- sequencer between a host register port, a single-port
// SRAM and an external activation unit.
//
// The host pushes input words into the lower half of the SRAM and starts a
// batch. The FSM reads each word, hands it to the activation unit, collects
// the result and writes it into the upper half of the SRAM. The host then
// pops the results back out.
//
// Optional feature: define NPU_SEQ_ERR_EN to enable the sticky err_o flag.
// It records every dropped host access. Without the macro, err_o is 0.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   wen_type_i            control write   (addr 0x0)
//   wen_input_i           input push      (addr 0x4)
//   ren_output_i          output pop (0x8) / status read (0xC)
//   addr_i, wdata_i       host address / write data
//   rdata_o, rvalid_o     host read data, valid one cycle after a read
//   busy_o, done_o, err_o batch running / batch complete / sticky error
//   act_*                 activation request (valid/ready) and result
//   mem_*                 single-port SRAM master, read data one cycle late
module npu_seq_ctrl #(
  parameter int DWidth = 32,
  parameter int Depth  = 16,
  localparam int MAW   = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wen_type_i,
  input  logic              wen_input_i,
  input  logic              ren_output_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic [DWidth-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              act_valid_o,
  input  logic              act_ready_i,
  output logic [DWidth-1:0] act_data_o,
  output logic [1:0]        act_type_o,
  input  logic              act_res_valid_i,
  input  logic [DWidth-1:0] act_res_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MAW-1:0]    mem_addr_o,
  output logic [DWidth-1:0] mem_wdata_o,
  input  logic [DWidth-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_ISSUE, S_COLLECT, S_WR, S_DONE
  } state_t;

  localparam logic [DWidth-1:0] ADDR_CTRL = DWidth'(32'h0);
  localparam logic [DWidth-1:0] ADDR_PUSH = DWidth'(32'h4);
  localparam logic [DWidth-1:0] ADDR_POP  = DWidth'(32'h8);
  localparam logic [DWidth-1:0] ADDR_STAT = DWidth'(32'hC);
  localparam logic [MAW-1:0]    OUT_BASE  = MAW'(Depth);

  state_t state, state_nxt;

  logic [MAW-1:0]    in_cnt, n, idx, out_ptr;
  logic [1:0]        type_q, run_type;
  logic [DWidth-1:0] data_q, res_q, rdata_q, status;
  logic              rvalid_q, rsel_mem;

  // Host request decode. Nothing from the host is honoured during reset.
  logic host_en, host_idle;
  logic sel_ctrl, sel_push, sel_pop, sel_stat, start_req;
  logic do_start, do_push, do_pop, pop_mem, last_elem;

  assign host_en   = !rst_i;
  assign host_idle = (state == S_IDLE) || (state == S_DONE);
  assign sel_ctrl  = host_en && wen_type_i   && (addr_i == ADDR_CTRL);
  assign sel_push  = host_en && wen_input_i  && (addr_i == ADDR_PUSH);
  assign sel_pop   = host_en && ren_output_i && (addr_i == ADDR_POP);
  assign sel_stat  = host_en && ren_output_i && (addr_i == ADDR_STAT);
  assign start_req = sel_ctrl && wdata_i[31];

  // A start owns the cycle: a push or pop in the same cycle is dropped.
  // A push beats a pop, because both need the single SRAM port.
  assign do_start  = start_req && host_idle;
  assign do_push   = sel_push && host_idle && !do_start && (in_cnt < OUT_BASE);
  assign do_pop    = sel_pop && host_idle && !do_start && !sel_push;
  assign pop_mem   = do_pop && (n != '0);  // an empty batch returns 0 without a read
  assign last_elem = (idx == n - MAW'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (do_start)                        state_nxt = (in_cnt == '0) ? S_DONE : S_RD;
        else if (do_push && state == S_DONE) state_nxt = S_IDLE;
      end
      S_RD:      state_nxt = S_WAIT;
      S_WAIT:    state_nxt = S_ISSUE;
      S_ISSUE:   if (act_ready_i)     state_nxt = S_COLLECT;
      S_COLLECT: if (act_res_valid_i) state_nxt = S_WR;
      S_WR:      state_nxt = last_elem ? S_DONE : S_RD;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs. The FSM owns the SRAM while busy and the host owns it otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state)
      S_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = idx;
      end
      S_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = OUT_BASE + idx;
        mem_wdata_o = res_q;
      end
      S_IDLE, S_DONE: begin
        if (do_push) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = in_cnt;
          mem_wdata_o = wdata_i;
        end else if (pop_mem) begin
          mem_req_o  = 1'b1;
          mem_addr_o = OUT_BASE + out_ptr;
        end
      end
      default: ;
    endcase
  end

  assign busy_o      = (state == S_RD) || (state == S_WAIT) || (state == S_ISSUE) ||
                       (state == S_COLLECT) || (state == S_WR);
  assign done_o      = (state == S_DONE);
  assign act_valid_o = (state == S_ISSUE);
  assign act_data_o  = act_valid_o ? data_q : '0;
  assign act_type_o  = act_valid_o ? run_type : '0;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = !rvalid_q ? '0 : (rsel_mem ? mem_rdata_i : rdata_q);

  always_comb begin
    status           = '0;
    status[DWidth-1] = err_o;
    status[DWidth-2] = done_o;
    status[DWidth-3] = busy_o;
    status[MAW-1:0]  = in_cnt;
  end

  // Datapath and counters.
  // NOTE: only control and bookkeeping flops are reset. data_q and res_q are
  // always written before they are used, and act_data_o is masked outside ISSUE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_cnt   <= '0;
      n        <= '0;
      idx      <= '0;
      out_ptr  <= '0;
      type_q   <= '0;
      run_type <= '0;
      rvalid_q <= 1'b0;
      rsel_mem <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // type_q may change mid-batch. run_type is captured on the first read
      // of a batch, so the running batch keeps its type.
      if (sel_ctrl) type_q <= wdata_i[1:0];
      if (state == S_RD && idx == '0) run_type <= type_q;

      if (do_start) begin
        n       <= in_cnt;
        idx     <= '0;
        out_ptr <= '0;
      end
      if (do_push) in_cnt <= in_cnt + MAW'(1);

      if (state == S_WR) begin
        if (last_elem) in_cnt <= '0;
        else           idx    <= idx + MAW'(1);
      end

      if (pop_mem) out_ptr <= (out_ptr == n - MAW'(1)) ? '0 : out_ptr + MAW'(1);

      rvalid_q <= do_pop || sel_stat;
      rsel_mem <= pop_mem;
      rdata_q  <= sel_stat ? status : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_WAIT)                       data_q <= mem_rdata_i;
    if (state == S_COLLECT && act_res_valid_i) res_q  <= act_res_data_i;
  end

`ifdef NPU_SEQ_ERR_EN
  logic drop, err_q;

  assign drop = (start_req && !host_idle) || (sel_push && !do_push) || (sel_pop && !do_pop);

  // A drop in the same cycle as a clear request still leaves err set.
  always_ff @(posedge clk_i) begin
    if (rst_i)                      err_q <= 1'b0;
    else if (drop)                  err_q <= 1'b1;
    else if (sel_ctrl && wdata_i[30]) err_q <= 1'b0;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
